bias_add_stream: RTL and testbench

Streaming bias-add stage for linear layers. It joins the matmul result stream with a bias parameter stream, one bias beat per data beat. The bias stream comes from a ROM-backed bias source that is always valid and advances on ready. Operands are aligned to a common fixed-point format, added, then cast to the output precision. The result is registered behind a skid buffer for full throughput, and each bias-length row is tagged with a last flag.

---
 rtl/bias_add_pkg.sv | 72 +++++++
 rtl/bias_add_skid.sv | 53 +++++
 rtl/bias_add_stream.sv | 118 +++++++++++
 tb/tb_bias_add_stream.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_add_pkg.sv
// bias_add_pkg: shared fixed-point helpers, default-configuration widths and
// the skid entry shape used by the bias_add_stream slice.
package bias_add_pkg;

  // Default precisions, matching the bias_add_stream parameter defaults
  localparam int DEFAULT_DIN_W        = 16;
  localparam int DEFAULT_DIN_F        = 3;
  localparam int DEFAULT_BIAS_W       = 16;
  localparam int DEFAULT_BIAS_F       = 3;
  localparam int DEFAULT_DOUT_W       = 16;
  localparam int DEFAULT_PARALLELISM  = 1;

  // Arithmetic is carried in a wide signed container; every intermediate
  // (aligned operand, sum, shifted sum) must fit inside it
  localparam int CONTAINER_W = 64;
  typedef logic signed [CONTAINER_W-1:0] fixed_t;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Common fractional position both operands are aligned to
  function automatic int alignFracBits(input int aFrac, input int bFrac);
    return maxInt(aFrac, bFrac);
  endfunction

  // Sum width: widest integer part plus one guard bit, plus the common fraction
  function automatic int sumWidth(input int aW, input int aFrac,
                                  input int bW, input int bFrac);
    return maxInt(aW - aFrac, bW - bFrac) + 1 + alignFracBits(aFrac, bFrac);
  endfunction

  localparam int DEFAULT_ALIGN_F = alignFracBits(DEFAULT_DIN_F, DEFAULT_BIAS_F);
  localparam int DEFAULT_SUM_W   = sumWidth(DEFAULT_DIN_W, DEFAULT_DIN_F,
                                            DEFAULT_BIAS_W, DEFAULT_BIAS_F);

  // Move a value between fractional positions: left shifts zero-fill,
  // right shifts are arithmetic so they truncate toward minus infinity
  function automatic fixed_t shiftFrac(input fixed_t value, input int fromFrac,
                                       input int toFrac);
    if (toFrac >= fromFrac) begin
      return value <<< (toFrac - fromFrac);
    end
    return value >>> (fromFrac - toFrac);
  endfunction

  // Clamp to the signed range of 'width' bits when saturating; otherwise pass
  // the value through and let the caller keep the low bits (two's-complement wrap)
  function automatic fixed_t reduceWidth(input fixed_t value, input int width,
                                         input bit saturate);
    fixed_t hi;
    fixed_t lo;
    hi = (fixed_t'(1) <<< (width - 1)) - fixed_t'(1);
    lo = -hi - fixed_t'(1);
    if (saturate) begin
      if (value > hi) begin
        return hi;
      end
      if (value < lo) begin
        return lo;
      end
    end
    return value;
  endfunction

  // Skid entry for the default configuration: packed result lanes plus row-last flag
  typedef struct packed {
    logic [DEFAULT_PARALLELISM*DEFAULT_DOUT_W-1:0] data;
    logic                                          last;
  } skid_entry_t;

endpackage

// File: rtl/bias_add_skid.sv
// bias_add_skid: two-entry (main + skid) register slice. The input ready is
// registered (it only depends on skid occupancy), so upstream sees no
// combinational path from the downstream ready.
module bias_add_skid #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  logic             r_mainValid;
  logic [WIDTH-1:0] r_mainData;
  logic             r_skidValid;
  logic [WIDTH-1:0] r_skidData;
  logic             w_push;

  assign o_ready = ~r_skidValid;
  assign w_push  = i_valid & ~r_skidValid;
  assign o_valid = r_mainValid;
  assign o_data  = r_mainData;

  // Main refills from skid first (ordering), else from the input; a push
  // arriving while main is stalled parks in skid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mainValid <= 1'b0;
      r_mainData  <= '0;
      r_skidValid <= 1'b0;
      r_skidData  <= '0;
    end else if (!r_mainValid || i_ready) begin
      if (r_skidValid) begin
        r_mainValid <= 1'b1;
        r_mainData  <= r_skidData;
        r_skidValid <= 1'b0;
      end else if (w_push) begin
        r_mainValid <= 1'b1;
        r_mainData  <= i_data;
      end else begin
        r_mainValid <= 1'b0;
      end
    end else if (w_push) begin
      r_skidValid <= 1'b1;
      r_skidData  <= i_data;
    end
  end

endmodule

// File: rtl/bias_add_stream.sv
// bias_add_stream: joins the matmul result stream with the bias stream,
// aligns both to a common fixed-point format, adds, casts to the output
// precision and registers the result behind a skid buffer with a row-last tag.
// Optional feature macro: BIAS_ADD_SATURATE_EN (clamp instead of wrap on cast).
module bias_add_stream
  import bias_add_pkg::*;
#(
  parameter int DATA_IN_PRECISION_0  = 16,
  parameter int DATA_IN_PRECISION_1  = 3,
  parameter int BIAS_PRECISION_0     = 16,
  parameter int BIAS_PRECISION_1     = 3,
  parameter int DATA_OUT_PRECISION_0 = 16,
  parameter int DATA_OUT_PRECISION_1 = 3,
  parameter int TENSOR_SIZE_DIM_0    = 32,
  parameter int PARALLELISM          = 1,
  parameter int DEPTH                = TENSOR_SIZE_DIM_0 / PARALLELISM
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_IN_PRECISION_0-1:0]  data_in [PARALLELISM],
  input  logic                            data_in_valid,
  output logic                            data_in_ready,
  input  logic [BIAS_PRECISION_0-1:0]     bias [PARALLELISM],
  input  logic                            bias_valid,
  output logic                            bias_ready,
  output logic [DATA_OUT_PRECISION_0-1:0] data_out [PARALLELISM],
  output logic                            data_out_valid,
  input  logic                            data_out_ready,
  output logic                            data_out_last
);

  localparam int ALIGN_F = alignFracBits(DATA_IN_PRECISION_1, BIAS_PRECISION_1);
  localparam int SUM_W   = sumWidth(DATA_IN_PRECISION_0, DATA_IN_PRECISION_1,
                                    BIAS_PRECISION_0, BIAS_PRECISION_1);
  localparam int COL_W   = $clog2(DEPTH) + 1;
  localparam int OUT_W   = DATA_OUT_PRECISION_0;

`ifdef BIAS_ADD_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  typedef struct packed {
    logic [PARALLELISM*OUT_W-1:0] data;
    logic                         last;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic                    w_skidReady;
  logic                    w_acc;
  logic                    w_fire;
  logic                    w_lastCol;
  logic [COL_W-1:0]        r_col;
  logic signed [SUM_W-1:0] w_sum [PARALLELISM];
  entry_t                  w_entryIn;
  entry_t                  w_entryOut;

  // Reset forces both readies low even if a skid entry was pending
  assign w_acc         = w_skidReady & ~rst;
  assign data_in_ready = bias_valid & w_acc;
  assign bias_ready    = data_in_valid & w_acc;
  assign w_fire        = data_in_valid & bias_valid & w_acc;
  assign w_lastCol     = (r_col == COL_W'(DEPTH - 1));

  // Align both operands to ALIGN_F fractional bits and add; SUM_W bits cannot overflow
  always_comb begin
    for (int i = 0; i < PARALLELISM; i++) begin
      w_sum[i] = SUM_W'(
        shiftFrac(fixed_t'(signed'(data_in[i])), DATA_IN_PRECISION_1, ALIGN_F) +
        shiftFrac(fixed_t'(signed'(bias[i])),    BIAS_PRECISION_1,    ALIGN_F));
    end
  end

  // Cast each lane to the output precision and pack it with the row-last flag
  always_comb begin
    w_entryIn = '0;
    for (int i = 0; i < PARALLELISM; i++) begin
      w_entryIn.data[i*OUT_W +: OUT_W] = OUT_W'(reduceWidth(
        shiftFrac(fixed_t'(w_sum[i]), ALIGN_F, DATA_OUT_PRECISION_1),
        OUT_W, SATURATE));
    end
    w_entryIn.last = w_lastCol;
  end

  // Column within the current row; advances only on a joined beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
    end else if (w_fire) begin
      r_col <= w_lastCol ? '0 : r_col + COL_W'(1);
    end
  end

  bias_add_skid #(
    .WIDTH (ENTRY_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_data  (w_entryIn),
    .i_valid (data_in_valid & bias_valid),
    .o_ready (w_skidReady),
    .o_data  (w_entryOut),
    .o_valid (data_out_valid),
    .i_ready (data_out_ready)
  );

  // Unpack the registered entry onto the output lanes
  always_comb begin
    for (int i = 0; i < PARALLELISM; i++) begin
      data_out[i] = w_entryOut.data[i*OUT_W +: OUT_W];
    end
  end

  assign data_out_last = w_entryOut.last;

endmodule

// File: tb/tb_bias_add_stream.sv
// tb_bias_add_stream: directed bench for bias_add_stream with a behavioural
// fixed-point model and a per-cycle stream comparison. A second instance uses
// BIAS_PRECISION_1=5 to exercise fractional alignment.
module tb_bias_add_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in [1];
  logic        data_in_valid;
  logic        data_in_ready;
  logic [15:0] bias [1];
  logic        bias_valid;
  logic        bias_ready;
  logic [15:0] data_out [1];
  logic        data_out_valid;
  logic        data_out_ready;
  logic        data_out_last;

  logic [15:0] fData [1];
  logic [15:0] fBias [1];
  logic        fInReady;
  logic        fBiasReady;
  logic [15:0] fOut [1];
  logic        fOutValid;
  logic        fOutLast;

  int passCount  = 0;
  int checkCount = 0;

  logic [16:0] expQ [$];
  int          lastIdx [$];
  int          outIdx = 0;
  int          firedSinceReset = 0;

  always #5 clk = ~clk;

  bias_add_stream dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .bias           (bias),
    .bias_valid     (bias_valid),
    .bias_ready     (bias_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_out_last  (data_out_last)
  );

  bias_add_stream #(
    .BIAS_PRECISION_1 (5)
  ) dutFrac (
    .clk            (clk),
    .rst            (rst),
    .data_in        (fData),
    .data_in_valid  (1'b1),
    .data_in_ready  (fInReady),
    .bias           (fBias),
    .bias_valid     (1'b1),
    .bias_ready     (fBiasReady),
    .data_out       (fOut),
    .data_out_valid (fOutValid),
    .data_out_ready (1'b1),
    .data_out_last  (fOutLast)
  );

  // Real-valued behaviour in scaled integers: value = raw / 2^frac, output has 3 fractional bits
  function automatic logic [15:0] modelOut(input logic [15:0] d, input logic [15:0] b,
                                           input int dFrac, input int bFrac);
    longint dv;
    longint bv;
    longint f;
    longint sum;
    longint div;
    longint q;
    logic [63:0] bits;
    dv  = longint'(signed'(d));
    bv  = longint'(signed'(b));
    f   = (dFrac > bFrac) ? dFrac : bFrac;
    sum = dv * (longint'(1) << (f - dFrac)) + bv * (longint'(1) << (f - bFrac));
    if (f <= 3) begin
      q = sum * (longint'(1) << (3 - f));
    end else begin
      div = longint'(1) << (f - 3);
      q = sum / div;
      if ((sum % div != 0) && (sum < 0)) q = q - 1;
    end
`ifdef BIAS_ADD_SATURATE_EN
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
`endif
    bits = 64'(q);
    return bits[15:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one joined beat (call just after a rising edge) and hold it until it fires
  task automatic applyStimulus(input logic [15:0] d, input logic [15:0] b);
    int waitCycles;
    waitCycles = 0;
    data_in[0] = d;
    bias[0] = b;
    data_in_valid = 1'b1;
    bias_valid = 1'b1;
    @(negedge clk);
    while (!data_in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!data_in_ready) begin
      checkCount++;
      $display("[TB] FAIL fireTimeout: got no fire, expected fire within 50 cycles");
    end
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    bias_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    data_out_ready = 1'b1;
    while ((expQ.size() != 0 || data_out_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drainEmpty", 64'(expQ.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset(input int cycles);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Stream scoreboard: every valid output cycle must show the oldest expected beat
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      lastIdx.delete();
      outIdx = 0;
      firedSinceReset = 0;
    end else begin
      if (data_out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("streamUnexpected", {47'd0, data_out_last, data_out[0]}, 64'h1_0000_0000);
        end else begin
          checkOutput("stream", {47'd0, data_out_last, data_out[0]}, {47'd0, expQ[0]});
          if (data_out_ready) begin
            if (expQ[0][16]) lastIdx.push_back(outIdx);
            void'(expQ.pop_front());
            outIdx++;
          end
        end
      end
      if (data_in_valid && bias_valid && data_in_ready) begin
        expQ.push_back({((firedSinceReset % 32) == 31), modelOut(data_in[0], bias[0], 3, 3)});
        firedSinceReset++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stallFires;
    rst = 1'b1;
    data_in[0] = 16'h0000;
    bias[0] = 16'h0000;
    data_in_valid = 1'b1;
    bias_valid = 1'b1;
    data_out_ready = 1'b1;
    fData[0] = 16'h0002;
    fBias[0] = 16'h0008;

    // Model pins
    checkOutput("modelBasic", 64'(modelOut(16'h000C, 16'h0002, 3, 3)), 64'h000E);
    checkOutput("modelFrac",  64'(modelOut(16'h0002, 16'h0008, 3, 5)), 64'h0004);
`ifdef BIAS_ADD_SATURATE_EN
    checkOutput("modelOvfHi", 64'(modelOut(16'h7FF0, 16'h0020, 3, 3)), 64'h7FFF);
    checkOutput("modelOvfLo", 64'(modelOut(16'h8000, 16'hFFF8, 3, 3)), 64'h8000);
`else
    checkOutput("modelOvfHi", 64'(modelOut(16'h7FF0, 16'h0020, 3, 3)), 64'h8010);
    checkOutput("modelOvfLo", 64'(modelOut(16'h8000, 16'hFFF8, 3, 3)), 64'h7FF8);
`endif

    // Reset state, with both valids high
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstInReady",   64'(data_in_ready), 64'd0);
    checkOutput("rstBiasReady", 64'(bias_ready), 64'd0);
    checkOutput("rstOutValid",  64'(data_out_valid), 64'd0);
    checkOutput("rstOutLast",   64'(data_out_last), 64'd0);
    checkOutput("rstOutData",   64'(data_out[0]), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    data_in_valid = 1'b0;
    bias_valid = 1'b0;

    // Basic add, one-cycle latency
    applyStimulus(16'h000C, 16'h0002);
    @(negedge clk);
    checkOutput("basicValid", 64'(data_out_valid), 64'd1);
    checkOutput("basicData",  64'(data_out[0]), 64'h000E);
    checkOutput("basicLast",  64'(data_out_last), 64'd0);
    checkOutput("fracValid",  64'(fOutValid), 64'd1);
    checkOutput("fracData",   64'(fOut[0]), 64'h0004);
    @(posedge clk);
    #1;

    // Overflow on the output cast
    applyStimulus(16'h7FF0, 16'h0020);
    @(negedge clk);
`ifdef BIAS_ADD_SATURATE_EN
    checkOutput("ovfHi", 64'(data_out[0]), 64'h7FFF);
`else
    checkOutput("ovfHi", 64'(data_out[0]), 64'h8010);
`endif
    @(posedge clk);
    #1;
    applyStimulus(16'h8000, 16'hFFF8);
    @(negedge clk);
`ifdef BIAS_ADD_SATURATE_EN
    checkOutput("ovfLo", 64'(data_out[0]), 64'h8000);
`else
    checkOutput("ovfLo", 64'(data_out[0]), 64'h7FF8);
`endif
    @(posedge clk);
    #1;
    waitDrain();

    // Row wrap: 64 beats, last on output beats 31 and 63
    pulseReset(1);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(16'(i * 3 + 1), 16'(i));
    end
    waitDrain();
    checkOutput("wrapLastCount", 64'(lastIdx.size()), 64'd2);
    if (lastIdx.size() == 2) begin
      checkOutput("wrapLastFirst",  64'(lastIdx[0]), 64'd31);
      checkOutput("wrapLastSecond", 64'(lastIdx[1]), 64'd63);
    end

    // Backpressure: data_out_ready low for three cycles mid-stream
    stallFires = 0;
    bias_valid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      data_in[0] = 16'(200 + k);
      bias[0] = 16'(k);
      data_in_valid = (k >= 3 && k <= 6) ? 1'b1 : 1'($urandom_range(0, 1));
      data_out_ready = !(k >= 4 && k <= 6);
      @(negedge clk);
      if (k >= 4 && k <= 6 && data_in_valid && data_in_ready) stallFires++;
      if (k == 5 || k == 6) begin
        checkOutput("stallInReady",   64'(data_in_ready), 64'd0);
        checkOutput("stallBiasReady", 64'(bias_ready), 64'd0);
      end
    end
    checkOutput("stallFires", 64'(stallFires), 64'd1);
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    bias_valid = 1'b0;
    waitDrain();

    // Reset mid-row after 10 beats; new row restarts at column 0
    pulseReset(1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(16'(i + 7), 16'h0001);
    end
    rst = 1'b1;
    data_in_valid = 1'b1;
    bias_valid = 1'b1;
    @(negedge clk);
    checkOutput("midRstInReady",   64'(data_in_ready), 64'd0);
    checkOutput("midRstBiasReady", 64'(bias_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    data_in_valid = 1'b0;
    bias_valid = 1'b0;
    @(negedge clk);
    checkOutput("midRstOutValid", 64'(data_out_valid), 64'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(16'hFF00 + 16'(i), 16'(i));
    end
    waitDrain();
    checkOutput("midRstLastCount", 64'(lastIdx.size()), 64'd1);
    if (lastIdx.size() == 1) begin
      checkOutput("midRstLastIdx", 64'(lastIdx[0]), 64'd31);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
